// File: rtl/image_sdram_writer.sv
// ---------------------------------------------------------------------------
// image_sdram_writer
//   Takes the ROM loader's byte-wide write bus while the image region
//   downloads. Pairs even/odd bytes into 16-bit words with byte enables,
//   queues the words in a small FIFO and drains them to the SDRAM write port
//   over a req/ack handshake.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   image_download      high while the image region streams
//   wr_8bit             single-cycle byte strobe (ignored unless image_download)
//   addr_8bit[25:0]     byte address relative to image start
//   data_8bit[7:0]      byte data
//   sdram_wr            write request, held until sdram_ack
//   sdram_addr[24:0]    word address = IMAGE_BASE + addr_8bit[25:1]
//   sdram_data[15:0]    {odd byte, even byte}
//   sdram_be[1:0]       bit0 = even byte, bit1 = odd byte
//   sdram_ack           single-cycle acceptance of the current request
//   busy                work outstanding anywhere in the block
//   overflow            sticky: a word was dropped on a full FIFO
// ---------------------------------------------------------------------------
module image_sdram_writer #(
    parameter logic [24:0] IMAGE_BASE = 25'h0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        image_download,
    input  logic        wr_8bit,
    input  logic [25:0] addr_8bit,
    input  logic [7:0]  data_8bit,
    output logic        sdram_wr,
    output logic [24:0] sdram_addr,
    output logic [15:0] sdram_data,
    output logic [1:0]  sdram_be,
    input  logic        sdram_ack,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } word_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    // Packer / staging state
    logic    r_dl_q;
    logic    r_pend_vld;
    word_t   r_pend;
    logic    r_head_vld;
    word_t   r_head;
    logic    r_skid_vld;
    word_t   r_skid;

    // FIFO state
    word_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    state_t r_state;

    logic        w_cap;
    logic [24:0] w_waddr;
    logic        w_same;
    logic        w_n0_vld, w_n1_vld;
    word_t       w_n0, w_n1, w_odd;
    logic        w_pend_vld_nxt;
    word_t       w_pend_nxt;
    logic        w_head_vld_nxt, w_skid_vld_nxt;
    word_t       w_head_nxt, w_skid_nxt;
    logic        w_full, w_empty, w_wr_ok, w_pop;

    // Packer: decide which words (at most two, in order) leave this cycle
    always_comb begin
        w_cap          = wr_8bit & image_download;
        w_waddr        = IMAGE_BASE + addr_8bit[25:1];
        w_same         = r_pend_vld && (r_pend.addr == w_waddr);
        w_odd          = '{addr: w_waddr, data: {data_8bit, 8'h00}, be: 2'b10};
        w_n0_vld       = 1'b0;
        w_n0           = r_pend;
        w_n1_vld       = 1'b0;
        w_n1           = w_odd;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        if (w_cap) begin
            if (!addr_8bit[0]) begin
                // A different pending word is flushed before the new even byte loads.
                w_n0_vld       = r_pend_vld && !w_same;
                w_pend_vld_nxt = 1'b1;
                w_pend_nxt     = '{addr: w_waddr, data: {8'h00, data_8bit}, be: 2'b01};
            end else begin
                w_pend_vld_nxt = 1'b0;
                if (w_same) begin
                    w_n0_vld = 1'b1;
                    w_n0     = '{addr: w_waddr, data: {data_8bit, r_pend.data[7:0]}, be: 2'b11};
                end else if (r_pend_vld) begin
                    w_n0_vld = 1'b1;
                    w_n1_vld = 1'b1;
                end else begin
                    w_n0_vld = 1'b1;
                    w_n0     = w_odd;
                end
            end
        end else if (r_dl_q && !image_download && r_pend_vld) begin
            // Download ended with a half-filled word.
            w_n0_vld       = 1'b1;
            w_pend_vld_nxt = 1'b0;
        end

        // Head is consumed every cycle, so the skid advances first and new
        // words queue behind it. A 2-word burst only follows a pending load,
        // which never pushes, so two slots always suffice.
        w_head_vld_nxt = 1'b0;
        w_head_nxt     = r_head;
        w_skid_vld_nxt = 1'b0;
        w_skid_nxt     = r_skid;
        if (r_skid_vld) begin
            w_head_vld_nxt = 1'b1;
            w_head_nxt     = r_skid;
            w_skid_vld_nxt = w_n0_vld;
            w_skid_nxt     = w_n0;
        end else if (w_n0_vld) begin
            w_head_vld_nxt = 1'b1;
            w_head_nxt     = w_n0;
            w_skid_vld_nxt = w_n1_vld;
            w_skid_nxt     = w_n1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_q     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            r_dl_q     <= image_download;
            r_pend_vld <= w_pend_vld_nxt;
            r_head_vld <= w_head_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_pend <= w_pend_nxt;
        r_head <= w_head_nxt;
        r_skid <= w_skid_nxt;
    end

    // FIFO: a push on a full cycle is dropped even if a pop happens too.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_wr_ok = r_head_vld && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr_ok && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_wr_ok && w_pop) r_count <= r_count - CW'(1);
            if (r_head_vld && w_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= r_head;
    end

    // Drain FSM: returning to IDLE after every ack gives the required idle gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            sdram_wr   <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
            sdram_be   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        sdram_addr <= r_mem[r_rd_ptr].addr;
                        sdram_data <= r_mem[r_rd_ptr].data;
                        sdram_be   <= r_mem[r_rd_ptr].be;
                        sdram_wr   <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sdram_ack) begin
                        sdram_wr <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_pend_vld | r_head_vld | r_skid_vld | !w_empty | sdram_wr;

endmodule
